// File: rtl/mem_rd_arbiter_if.sv
// Bundles the requester handshake, response return and memory read port of mem_rd_arbiter.
// No storage or latency: wires only.
// Modport slave is the arbiter. Modport master is the surrounding logic: requesters plus the memory read data.
interface mem_rd_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int WIDTH_DATA = 8,
    parameter int WIDTH_ADDR = 8
);
    logic                          arb_en;
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*WIDTH_ADDR-1:0] req_addr;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ-1:0]            rsp_valid;
    logic [WIDTH_DATA-1:0]         rsp_data;
    logic                          mem_ren;
    logic [WIDTH_ADDR-1:0]         mem_raddr;
    logic [WIDTH_DATA-1:0]         mem_dout;

    // The master side drives requests and carries the memory's read data back in.
    modport master (
        output arb_en, req_valid, req_addr, mem_dout,
        input  req_ready, rsp_valid, rsp_data, mem_ren, mem_raddr
    );

    // The arbiter grants requests and drives the memory read port.
    modport slave (
        input  arb_en, req_valid, req_addr, mem_dout,
        output req_ready, rsp_valid, rsp_data, mem_ren, mem_raddr
    );
endinterface

// File: rtl/mem_rd_arbiter.sv
// Round-robin sharing of one memory read port among NUM_REQ requesters. Optional macro MEM_RD_ARB_PRIO0_EN makes requester 0 strict priority.
// Grant and memory read are combinational in the request cycle. The one-hot response is returned READ_LATENCY cycles later.
// Requesters wait while unselected or while arb_en is low. Responses cannot be stalled.
module mem_rd_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int WIDTH_DATA   = 8,
    parameter int WIDTH_ADDR   = 8,
    parameter int READ_LATENCY = 1
) (
    input  logic             clk,
    input  logic             rst,
    mem_rd_arbiter_if.slave  bus
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0]   rr_ptr;
    logic [NUM_REQ-1:0] req_eff;
    logic [NUM_REQ-1:0] rr_req;
    logic [NUM_REQ-1:0] rr_hi;
    logic [PTR_W-1:0]   rr_start;
    logic [PTR_W-1:0]   grant_idx;
    logic               grant_any;
    logic [NUM_REQ-1:0] grant;
    logic [WIDTH_ADDR-1:0] raddr;
    logic [NUM_REQ-1:0] rsp_pipe [READ_LATENCY];

    // Return the index of the lowest set bit, or 0 when no bit is set.
    function automatic logic [PTR_W-1:0] low_idx(input logic [NUM_REQ-1:0] v);
        low_idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (v[i]) low_idx = PTR_W'(i);
        end
    endfunction

    // Select a requester: first search upward from rr_ptr, then wrap around to the lowest index.
    always_comb begin
        req_eff = (bus.arb_en && !rst) ? bus.req_valid : '0;
`ifdef MEM_RD_ARB_PRIO0_EN
        // Requester 0 is handled outside the rotation, so the rotation never starts at index 0.
        rr_req   = req_eff & ~NUM_REQ'(1);
        rr_start = (rr_ptr == '0) ? PTR_W'(1) : rr_ptr;
`else
        rr_req   = req_eff;
        rr_start = rr_ptr;
`endif
        rr_hi = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rr_hi[i] = rr_req[i] && (i >= int'(rr_start));
        end
        grant_any = |req_eff;
        grant_idx = (|rr_hi) ? low_idx(rr_hi) : low_idx(rr_req);
`ifdef MEM_RD_ARB_PRIO0_EN
        if (req_eff[0]) grant_idx = '0;
`endif
        grant = '0;
        if (grant_any) grant[grant_idx] = 1'b1;
    end

    // Pass the granted requester's address to the memory; the address is zero when nothing is granted.
    always_comb begin
        raddr = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) raddr = bus.req_addr[i*WIDTH_ADDR +: WIDTH_ADDR];
        end
    end

    // Advance the pointer past the winner. A strict-priority win leaves the rotation unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (grant_any) begin
`ifdef MEM_RD_ARB_PRIO0_EN
            if (grant_idx != '0)
`endif
            rr_ptr <= (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + PTR_W'(1);
        end
    end

    // Carry each grant alongside its read so the response strobe lines up with mem_dout. Reset drops in-flight reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < READ_LATENCY; i++) rsp_pipe[i] <= '0;
        end else begin
            rsp_pipe[0] <= grant;
            for (int i = 1; i < READ_LATENCY; i++) rsp_pipe[i] <= rsp_pipe[i-1];
        end
    end

    assign bus.req_ready = grant;
    assign bus.mem_ren   = grant_any;
    assign bus.mem_raddr = raddr;
    assign bus.rsp_valid = rsp_pipe[READ_LATENCY-1];
    assign bus.rsp_data  = bus.mem_dout;
endmodule

// File: tb/tb_mem_rd_arbiter.sv
// Self-checking bench for mem_rd_arbiter. One copy has READ_LATENCY=1 and the other has READ_LATENCY=2; both receive the same stimulus.
// A per-cycle behavioural model, which uses a grant history and a modulo search, checks every output, and literal checks fix the model to known values.
// Memory contents are constant, so the expected read data is a lookup in the bench's memory array.
module tb_mem_rd_arbiter;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       arb_en = 1'b0;
    logic [3:0] req_valid = 4'b0;
    logic       chk_on = 1'b0;
    int         n_pass = 0;
    int         n_chk = 0;

    logic [7:0] addr_tab [4] = '{8'h08, 8'h21, 8'h10, 8'h37};
    logic [7:0] mem [256];

    always #5 clk = ~clk;

    mem_rd_arbiter_if #(.NUM_REQ(4), .WIDTH_DATA(8), .WIDTH_ADDR(8)) if0 ();
    mem_rd_arbiter_if #(.NUM_REQ(4), .WIDTH_DATA(8), .WIDTH_ADDR(8)) if1 ();

    mem_rd_arbiter #(.NUM_REQ(4), .WIDTH_DATA(8), .WIDTH_ADDR(8), .READ_LATENCY(1)) dut0 (
        .clk(clk), .rst(rst), .bus(if0.slave));
    mem_rd_arbiter #(.NUM_REQ(4), .WIDTH_DATA(8), .WIDTH_ADDR(8), .READ_LATENCY(2)) dut1 (
        .clk(clk), .rst(rst), .bus(if1.slave));

    assign if0.arb_en    = arb_en;
    assign if1.arb_en    = arb_en;
    assign if0.req_valid = req_valid;
    assign if1.req_valid = req_valid;
    assign if0.req_addr  = {addr_tab[3], addr_tab[2], addr_tab[1], addr_tab[0]};
    assign if1.req_addr  = {addr_tab[3], addr_tab[2], addr_tab[1], addr_tab[0]};

    // Read-first memories with one and two read stages. No writes occur, so contents stay constant.
    logic [7:0] m1q, m2a, m2b;
    always @(posedge clk) if (if0.mem_ren) m1q <= mem[if0.mem_raddr];
    always @(posedge clk) begin
        if (if1.mem_ren) m2a <= mem[if1.mem_raddr];
        m2b <= m2a;
    end
    assign if0.mem_dout = m1q;
    assign if1.mem_dout = m2b;

    logic [3:0] rdy [2];
    logic [3:0] rsp [2];
    logic       ren [2];
    logic [7:0] raddr [2];
    logic [7:0] dat [2];
    assign rdy[0] = if0.req_ready;  assign rdy[1] = if1.req_ready;
    assign rsp[0] = if0.rsp_valid;  assign rsp[1] = if1.rsp_valid;
    assign ren[0] = if0.mem_ren;    assign ren[1] = if1.mem_ren;
    assign raddr[0] = if0.mem_raddr; assign raddr[1] = if1.mem_raddr;
    assign dat[0] = if0.rsp_data;   assign dat[1] = if1.rsp_data;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // Model state: the rotation pointer and the expected grant and address for each cycle.
    int         ptr_m [2] = '{0, 0};
    logic [3:0] hist_g [2][1024];
    logic [7:0] hist_a [2][1024];
    int         n = 0;

    initial begin
        for (int a = 0; a < 256; a++) mem[a] = 8'(a * 3 + 7);
        mem[8'h10] = 8'hA5;
        for (int d = 0; d < 2; d++)
            for (int c = 0; c < 1024; c++) begin
                hist_g[d][c] = 4'b0;
                hist_a[d][c] = 8'h0;
            end
    end

    // Compare process: on each cycle, compute the model's expected outputs and check both DUT copies.
    always @(negedge clk) begin
        if (chk_on && n < 1024) begin
            for (int d = 0; d < 2; d++) begin
                int lat, g, idx, st;
                logic [3:0] er, ersp;
                logic [7:0] ea;
                lat = d + 1;
                g = -1;
                if (!rst && arb_en) begin
`ifdef MEM_RD_ARB_PRIO0_EN
                    if (req_valid[0]) g = 0;
                    else begin
                        st = (ptr_m[d] == 0) ? 1 : ptr_m[d];
                        for (int k = 0; k < 4; k++) begin
                            idx = (st + k) % 4;
                            if (g < 0 && idx != 0 && req_valid[idx]) g = idx;
                        end
                    end
`else
                    st = ptr_m[d];
                    for (int k = 0; k < 4; k++) begin
                        idx = (st + k) % 4;
                        if (g < 0 && req_valid[idx]) g = idx;
                    end
`endif
                end
                er = (g < 0) ? 4'b0 : 4'(1 << g);
                ea = (g < 0) ? 8'h0 : addr_tab[g];
                chk(d == 0 ? "req_ready_L1" : "req_ready_L2", 32'(rdy[d]), 32'(er));
                chk(d == 0 ? "mem_ren_L1" : "mem_ren_L2", 32'(ren[d]), 32'(g >= 0));
                chk(d == 0 ? "mem_raddr_L1" : "mem_raddr_L2", 32'(raddr[d]), 32'(ea));
                ersp = (n >= lat) ? hist_g[d][n-lat] : 4'b0;
                chk(d == 0 ? "rsp_valid_L1" : "rsp_valid_L2", 32'(rsp[d]), 32'(ersp));
                if (ersp != 4'b0)
                    chk(d == 0 ? "rsp_data_L1" : "rsp_data_L2", 32'(dat[d]), 32'(mem[hist_a[d][n-lat]]));
                hist_g[d][n] = er;
                hist_a[d][n] = ea;
                if (rst) begin
                    ptr_m[d] = 0;
                    for (int c = n - lat + 1; c < n; c++) if (c >= 0) hist_g[d][c] = 4'b0;
                end else if (g >= 0) begin
`ifdef MEM_RD_ARB_PRIO0_EN
                    if (g != 0) ptr_m[d] = (g + 1) % 4;
`else
                    ptr_m[d] = (g + 1) % 4;
`endif
                end
            end
            n++;
        end
    end

    // Drive one cycle of stimulus just after the rising edge.
    task automatic step(input logic [3:0] v, input logic en, input logic r);
        @(posedge clk);
        #1;
        rst = r;
        arb_en = en;
        req_valid = v;
    endtask

    logic [3:0] exp_v;

    initial begin
        repeat (2) @(posedge clk);
        #1 chk_on = 1'b1;

        // Reset gates grants even when every requester is valid.
        step(4'b1111, 1'b1, 1'b1); @(negedge clk);
        chk("rst_req_ready", 32'(rdy[0]), 32'h0);
        chk("rst_mem_ren", 32'(ren[0]), 32'h0);
        chk("rst_rsp_valid_L1", 32'(rsp[0]), 32'h0);
        chk("rst_rsp_valid_L2", 32'(rsp[1]), 32'h0);

        // Single read by requester 2 at address 0x10.
        step(4'b0100, 1'b1, 1'b0); @(negedge clk);
        chk("single_ready", 32'(rdy[0]), 32'h4);
        chk("single_ren", 32'(ren[0]), 32'h1);
        chk("single_raddr", 32'(raddr[0]), 32'h10);
        step(4'b0000, 1'b1, 1'b0); @(negedge clk);
        chk("single_rsp_L1", 32'(rsp[0]), 32'h4);
        chk("single_data_L1", 32'(dat[0]), 32'hA5);
        step(4'b0000, 1'b1, 1'b0); @(negedge clk);
        chk("single_rsp_L2", 32'(rsp[1]), 32'h4);
        chk("single_data_L2", 32'(dat[1]), 32'hA5);

        // All requesters valid for 8 cycles.
        step(4'b0000, 1'b1, 1'b1);
        for (int k = 0; k < 8; k++) begin
            step(4'b1111, 1'b1, 1'b0); @(negedge clk);
`ifdef MEM_RD_ARB_PRIO0_EN
            exp_v = 4'b0001;
`else
            exp_v = 4'(1 << (k % 4));
`endif
            chk("rr_order", 32'(rdy[0]), 32'(exp_v));
        end
        step(4'b0000, 1'b1, 1'b0); @(negedge clk);
        chk("rr_last_rsp", 32'(rsp[0]), 32'(exp_v));

        // Requesters 1 and 3 with READ_LATENCY=2.
        step(4'b0000, 1'b1, 1'b1);
        step(4'b1010, 1'b1, 1'b0); @(negedge clk);
        chk("l2_grant1", 32'(rdy[1]), 32'h2);
        step(4'b1000, 1'b1, 1'b0); @(negedge clk);
        chk("l2_grant3", 32'(rdy[1]), 32'h8);
        step(4'b0000, 1'b1, 1'b0); @(negedge clk);
        chk("l2_rsp1", 32'(rsp[1]), 32'h2);
        chk("l2_data1", 32'(dat[1]), 32'h6A);
        step(4'b0000, 1'b1, 1'b0); @(negedge clk);
        chk("l2_rsp3", 32'(rsp[1]), 32'h8);
        chk("l2_data3", 32'(dat[1]), 32'hAC);

        // Drop arb_en after a grant: the in-flight response still returns and no new grant is issued.
        step(4'b0000, 1'b1, 1'b1);
        step(4'b0011, 1'b1, 1'b0); @(negedge clk);
        chk("en_grant0", 32'(rdy[0]), 32'h1);
        step(4'b0010, 1'b0, 1'b0); @(negedge clk);
        chk("en_off_ready", 32'(rdy[0]), 32'h0);
        chk("en_off_rsp_L1", 32'(rsp[0]), 32'h1);
        step(4'b0010, 1'b0, 1'b0); @(negedge clk);
        chk("en_off_ready2", 32'(rdy[0]), 32'h0);
        chk("en_off_rsp_L2", 32'(rsp[1]), 32'h1);
        step(4'b0010, 1'b1, 1'b0); @(negedge clk);
        chk("en_on_grant1", 32'(rdy[0]), 32'h2);

        // Reset one cycle after an accept discards the read; requester 0 then has priority.
        step(4'b0000, 1'b1, 1'b1);
        step(4'b0001, 1'b1, 1'b0); @(negedge clk);
        chk("rst_mid_grant", 32'(rdy[1]), 32'h1);
        step(4'b0000, 1'b1, 1'b1);
        step(4'b1111, 1'b1, 1'b0); @(negedge clk);
        chk("rst_mid_no_rsp", 32'(rsp[1]), 32'h0);
        chk("rst_mid_prio0", 32'(rdy[1]), 32'h1);
        step(4'b0000, 1'b1, 1'b0); @(negedge clk);
        chk("rst_mid_no_rsp2", 32'(rsp[1]), 32'h0);

        // Requesters 0 and 2 contend for 3 cycles, then only requester 2 remains.
        step(4'b0000, 1'b1, 1'b1);
        for (int k = 0; k < 3; k++) begin
            step(4'b0101, 1'b1, 1'b0); @(negedge clk);
`ifdef MEM_RD_ARB_PRIO0_EN
            exp_v = 4'b0001;
`else
            exp_v = (k % 2 == 1) ? 4'b0100 : 4'b0001;
`endif
            chk("prio_contend", 32'(rdy[0]), 32'(exp_v));
        end
        step(4'b0100, 1'b1, 1'b0); @(negedge clk);
        chk("prio_drop0", 32'(rdy[0]), 32'h4);

        repeat (3) step(4'b0000, 1'b1, 1'b0);
        @(posedge clk);
        #1 chk_on = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/mem_rd_arbiter.md
Name: mem_rd_arbiter

Overview:
- Round-robin arbiter that shares the single read port of a simple-dual-port 1R1W memory (independent write port, read port with enable, address and data out) between NUM_REQ requesters.
- Accepts one read per cycle and tracks each accepted read through the fixed memory read latency.
- Returns the read data with a one-hot response valid to the requester that issued it.
- Sits between per-queue consumers (for example TX schedulers) and a shared descriptor/context RAM; the write port is driven separately and is untouched by this block.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- WIDTH_DATA, 8, memory data width.
- WIDTH_ADDR, 8, memory address width.
- READ_LATENCY, 1, memory read latency in cycles. 1 = unregistered output, 2 = registered output. Must match the memory instance.

Ports:
- clk  in  1  single clock, shared with the memory read port.
- rst  in  1  synchronous reset, active-high.
- arb_en  in  1  grant enable. When low, no new grants are issued.
- req_valid  in  NUM_REQ  per-requester read request.
- req_addr  in  NUM_REQ*WIDTH_ADDR  packed addresses. Requester i uses bits [i*WIDTH_ADDR +: WIDTH_ADDR].
- req_ready  out  NUM_REQ  one-hot grant; request i is accepted when req_valid[i] & req_ready[i].
- rsp_valid  out  NUM_REQ  one-hot response strobe.
- rsp_data  out  WIDTH_DATA  read data, shared by all requesters and qualified by rsp_valid.
- mem_ren  out  1  memory read enable.
- mem_raddr  out  WIDTH_ADDR  memory read address.
- mem_dout  in  WIDTH_DATA  memory read data.

Behaviour:
- Grant is combinational from req_valid, arb_en and the registered round-robin pointer rr_ptr (width clog2(NUM_REQ), minimum 1).
- Selection: the first requester with req_valid high, searching from index rr_ptr upward modulo NUM_REQ.
- req_ready has at most one bit set. It is all-zero when arb_en=0, when rst=1, or when no request is valid.
- req_ready does not depend on the ready of any other requester. Requesters may hold valid without a grant indefinitely; address must stay stable while valid is high.
- mem_ren = |req_ready. mem_raddr = address of the granted requester, or all-zero when there is no grant.
- rr_ptr update: on an accept by requester g, rr_ptr <= (g+1) mod NUM_REQ. With no accept, rr_ptr holds.
- Wrap-around: a grant to NUM_REQ-1 sets rr_ptr to 0.
- Response pipeline: a shift register of READ_LATENCY stages, each NUM_REQ bits one-hot, loaded with req_ready every cycle.
- rsp_valid = last stage, so rsp_valid[g] is high exactly READ_LATENCY cycles after the accept cycle.
- rsp_data = mem_dout, passed through combinationally. rsp_data is don't-care when rsp_valid = 0.
- Throughput: one accept per cycle sustained. Back-to-back grants to the same requester are allowed only when no other requester is valid.
- Responses have no backpressure; requesters must sink rsp_valid unconditionally.
- Responses come back in accept order, one per cycle maximum.
- arb_en deasserted mid-stream: in-flight reads still return their responses; no new grants are issued.
- Same-cycle write to the address being read: the memory is read-first, so the response carries the old data. The arbiter takes no action.
- Reset values: rr_ptr=0, all response pipeline stages=0, rsp_valid=0, req_ready=0, mem_ren=0. In-flight reads at reset are discarded (no response).
- First cycle after reset deassertion: requester 0 has top priority.

Optional Feature:
- Macro MEM_RD_ARB_PRIO0_EN.
- Defined: requester 0 is strict high priority. If req_valid[0] & arb_en, requester 0 is granted regardless of rr_ptr and rr_ptr is not updated. Requesters 1..NUM_REQ-1 are round-robin among themselves via rr_ptr; when rr_ptr=0, the search for them starts at index 1.
- Undefined: plain round-robin over all requesters, as described above.

Test Plan:
- Reset, then requester 2 requests addr 0x10 with arb_en=1 (READ_LATENCY=1):
  - req_ready=4'b0100 and mem_ren=1, mem_raddr=0x10 in the same cycle.
  - Next cycle rsp_valid=4'b0100 and rsp_data equals the memory contents at 0x10 (preloaded to 0xA5).
- All four requesters valid continuously for 8 cycles:
  - Grant order is 0,1,2,3,0,1,2,3, one per cycle.
  - Each rsp_valid follows its grant by READ_LATENCY.
  - rr_ptr returns to 0 after the grant to 3.
- READ_LATENCY=2, requesters 1 and 3 valid:
  - Grants are 1 then 3 on consecutive cycles.
  - rsp_valid is 4'b0010 at accept+2, then 4'b1000 at accept+3, with matching data.
- arb_en driven low the cycle after granting requester 0 while requester 1 is valid:
  - Requester 0's response still arrives.
  - req_ready stays 0 until arb_en=1; then requester 1 is granted.
- rst asserted one cycle after an accept with READ_LATENCY=2:
  - No rsp_valid is produced.
  - After release, rr_ptr=0 and requester 0 wins a 0/1/2/3 contention.
- With MEM_RD_ARB_PRIO0_EN defined, requesters 0 and 2 valid for 3 cycles:
  - Requester 0 is granted every cycle.
  - When requester 0 drops, requester 2 is granted.
  - Without the macro, grants alternate 0,2,0.
